pipeline_ctrl: RTL and testbench

- Central stall/flush generator for the 5-stage pipeline. It is the driving end of the enable / sync-clear interface of every inter-stage pipeline register.
- Detects load-use hazards, taken branches, multicycle mul/div occupancy of EX, and data-memory wait states.
- Drives per-stage register enables and active-low sync clears (flush_n feeds the register srst, which clears regardless of en). Also drives the PC enable.

---
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush generator for the 5-stage pipeline.
// Drives the PC enable plus per-stage register enables and active-low
// sync clears. Handles load-use hazards, taken branches, multicycle
// mul/div occupancy of EX and data-memory wait states.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// Handshake: this block has no valid/ready pair. A stage register loads
// when its *_en is high. Its *_flush_n clears it on the next edge
// regardless of *_en. mem_req/mem_ready complete a data access in the
// cycle where both are high.
module pipeline_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MULDIV_LAT = 32,
   parameter int CNT_W      = $clog2(MULDIV_LAT)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  ex_muldiv_start,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  idex_en,
   output logic                  exmem_en,
   output logic                  memwb_en,
   output logic                  ifid_flush_n,
   output logic                  idex_flush_n,
   output logic                  exmem_flush_n,
   output logic                  memwb_flush_n,
   output logic                  muldiv_busy
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flush_events
`endif
);

   typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               mem_wait;
   logic               muldiv_stall;
   logic               load_use;
   logic               flush_evt;

   // Hazard detection terms; register x0 never creates a dependency.
   assign mem_wait     = mem_req && !mem_ready;
   assign muldiv_stall = ((state == RUN) && ex_muldiv_start) ||
                         ((state == MULDIV) && (cnt != CNT_W'(1)));
   assign load_use     = ex_mem_read && (ex_rd != '0) &&
                         ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                          (id_uses_rs2 && (id_rs2 == ex_rd)));

   // State and mul/div counter register.
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and Mealy outputs, priority memwait > muldiv > branch > load-use.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush_n  = 1'b1;
      idex_flush_n  = 1'b1;
      exmem_flush_n = 1'b1;
      memwb_flush_n = 1'b1;
      muldiv_busy   = (state == MULDIV) && !srst;
      flush_evt     = 1'b0;
      if (srst) begin
         // Clear every stage. Hold the PC this cycle.
         pc_en         = 1'b0;
         ifid_flush_n  = 1'b0;
         idex_flush_n  = 1'b0;
         exmem_flush_n = 1'b0;
         memwb_flush_n = 1'b0;
         state_nxt     = RUN;
         cnt_nxt       = '0;
      end else if (mem_wait) begin
         // Freeze the whole pipe without inserting bubbles.
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (muldiv_stall) begin
         // Hold the front of the pipe. Send bubbles into MEM while EX is busy.
         pc_en         = 1'b0;
         ifid_en       = 1'b0;
         idex_en       = 1'b0;
         exmem_flush_n = 1'b0;
         if (state == RUN) begin
            state_nxt = MULDIV;
            cnt_nxt   = CNT_W'(MULDIV_LAT - 1);
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end else if (state == MULDIV) begin
         // Release cycle: the mul/div result advances into EX/MEM.
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else if (ex_branch_taken) begin
         // Squash the two wrong-path instructions in IF/ID and ID/EX.
         ifid_flush_n = 1'b0;
         idex_flush_n = 1'b0;
         flush_evt    = 1'b1;
      end else if (load_use) begin
         // Hold IF/ID and the PC. Insert one bubble into ID/EX.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_flush_n = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Stall-cycle and branch-flush counters, free-running with wrap.
   always_ff @(posedge clk) begin
      if (srst) begin
         perf_stall_cycles <= '0;
         perf_flush_events <= '0;
      end else begin
         if (!pc_en) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush_evt) perf_flush_events <= perf_flush_events + 32'd1;
      end
   end
`else
   logic unused_flush_evt;
   assign unused_flush_evt = flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl with MULDIV_LAT=4.
// Perf counter checks are compiled in when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

   logic       clk;
   logic       srst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2;
   logic       ex_mem_read, ex_branch_taken, ex_muldiv_start;
   logic       mem_req, mem_ready;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n;
   logic       muldiv_busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

   int checks = 0;
   int errors = 0;

   // Output bundle: {pc_en, en[4], flush_n[4], muldiv_busy}
   logic [9:0] obs;
   assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n,
                 muldiv_busy};

   localparam logic [9:0] EXP_RESET   = {1'b0, 4'b1111, 4'b0000, 1'b0};
   localparam logic [9:0] EXP_DEFAULT = {1'b1, 4'b1111, 4'b1111, 1'b0};
   localparam logic [9:0] EXP_LOADUSE = {1'b0, 4'b0111, 4'b1011, 1'b0};
   localparam logic [9:0] EXP_BRANCH  = {1'b1, 4'b1111, 4'b0011, 1'b0};
   localparam logic [9:0] EXP_MD_RUN  = {1'b0, 4'b0011, 4'b1101, 1'b0};
   localparam logic [9:0] EXP_MD_BUSY = {1'b0, 4'b0011, 4'b1101, 1'b1};
   localparam logic [9:0] EXP_RELEASE = {1'b1, 4'b1111, 4'b1111, 1'b1};
   localparam logic [9:0] EXP_FRZ_RUN = {1'b0, 4'b0000, 4'b1111, 1'b0};
   localparam logic [9:0] EXP_FRZ_MD  = {1'b0, 4'b0000, 4'b1111, 1'b1};

   pipeline_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4)) dut (
      .clk(clk), .srst(srst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush_n(ifid_flush_n), .idex_flush_n(idex_flush_n),
      .exmem_flush_n(exmem_flush_n), .memwb_flush_n(memwb_flush_n),
      .muldiv_busy(muldiv_busy)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_events(perf_flush_events)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Check the settled outputs mid-cycle, then advance past the next edge.
   task automatic step(input string tag, input logic [9:0] exp);
      @(negedge clk);
      check(tag, {22'd0, obs}, {22'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
   endtask

   initial begin
      idle_inputs();
      srst = 1'b1;
      // Reset held for two cycles
      step("reset0", EXP_RESET);
      step("reset1", EXP_RESET);
      srst = 1'b0;
      step("after_reset", EXP_DEFAULT);

      // Load-use via rs2, then cleared
      set_load_use(5'd5);
      step("loaduse_rs2", EXP_LOADUSE);
      ex_mem_read = 1'b0;
      step("loaduse_clear", EXP_DEFAULT);
      // x0 never hazards
      set_load_use(5'd0);
      step("loaduse_x0", EXP_DEFAULT);
      idle_inputs();
      // Load-use via rs1, and rs1 match with uses_rs1 low
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      step("loaduse_rs1", EXP_LOADUSE);
      id_uses_rs1 = 1'b0;
      step("loaduse_unused", EXP_DEFAULT);
      idle_inputs();

      // Branch wins over load-use
      set_load_use(5'd9);
      ex_branch_taken = 1'b1;
      step("branch_over_lu", EXP_BRANCH);
      idle_inputs();

      // Memory wait in RUN, then ready completes without a stall
      mem_req = 1'b1; mem_ready = 1'b0;
      step("memwait_run", EXP_FRZ_RUN);
      mem_ready = 1'b1;
      step("mem_ready", EXP_DEFAULT);
      idle_inputs();

      // Mul/div, latency 4
      ex_muldiv_start = 1'b1;
      step("md_c0", EXP_MD_RUN);
      ex_muldiv_start = 1'b0;
      step("md_c1", EXP_MD_BUSY);
      step("md_c2", EXP_MD_BUSY);
      step("md_c3_release", EXP_RELEASE);
      step("md_c4_run", EXP_DEFAULT);

      // Mul/div with three memwait cycles starting at cycle 2
      ex_muldiv_start = 1'b1;
      step("mdw_c0", EXP_MD_RUN);
      ex_muldiv_start = 1'b0;
      step("mdw_c1", EXP_MD_BUSY);
      mem_req = 1'b1; mem_ready = 1'b0;
      step("mdw_c2_frz", EXP_FRZ_MD);
      step("mdw_c3_frz", EXP_FRZ_MD);
      step("mdw_c4_frz", EXP_FRZ_MD);
      mem_req = 1'b0;
      step("mdw_c5", EXP_MD_BUSY);
      step("mdw_c6_release", EXP_RELEASE);
      step("mdw_c7_run", EXP_DEFAULT);

      // Start held high is ignored while in MULDIV; branch ignored during busy
      ex_muldiv_start = 1'b1;
      step("mdh_c0", EXP_MD_RUN);
      ex_branch_taken = 1'b1;
      step("mdh_c1", EXP_MD_BUSY);
      ex_branch_taken = 1'b0;
      step("mdh_c2", EXP_MD_BUSY);
      step("mdh_c3_release", EXP_RELEASE);
      step("mdh_c4_restart", EXP_MD_RUN);
      ex_muldiv_start = 1'b0;
      // srst mid-MULDIV
      srst = 1'b1;
      step("md_srst", EXP_RESET);
      srst = 1'b0;
      step("md_srst_after", EXP_DEFAULT);

`ifdef PIPE_CTRL_PERF_EN
      srst = 1'b1;
      step("perf_reset", EXP_RESET);
      srst = 1'b0;
      @(negedge clk);
      check("perf_stall_zero", perf_stall_cycles, 32'd0);
      check("perf_flush_zero", perf_flush_events, 32'd0);
      for (int i = 0; i < 3; i++) begin
         set_load_use(5'd3);
         step("perf_lu", EXP_LOADUSE);
         idle_inputs();
         step("perf_gap", EXP_DEFAULT);
      end
      for (int i = 0; i < 2; i++) begin
         ex_branch_taken = 1'b1;
         step("perf_br", EXP_BRANCH);
         idle_inputs();
      end
      @(negedge clk);
      check("perf_stall_cycles", perf_stall_cycles, 32'd3);
      check("perf_flush_events", perf_flush_events, 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
